// File: rtl/clk_divider_bank.sv
// Bank of NCH programmable 50%-duty clock dividers with one-cycle tick strobes,
// glitch-free runtime half-period updates and a global phase-align strobe.
module clk_divider_bank #(
  parameter int NCH            = 4,
  parameter int PW             = 30,
  parameter int DEFAULT_PERIOD = 25000000
) (
  input  logic           CLK_50M,
  input  logic           RST,
  input  logic [NCH-1:0] en,
  input  logic           wr_en,
  input  logic [2:0]     wr_ch,
  input  logic [PW-1:0]  wr_period,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy
);

  localparam logic [PW-1:0] DEF_P  = PW'(DEFAULT_PERIOD);
  localparam logic [PW-1:0] ZERO_P = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]  active_r  [NCH];
  logic [PW-1:0]  pending_r [NCH];
  logic [PW-1:0]  cnt_r     [NCH];
  logic [NCH-1:0] clk_r;
  logic [NCH-1:0] tick_r;
  logic [NCH-1:0] busy_r;

  logic [PW-1:0]  last_s    [NCH];
  logic [NCH-1:0] wr_hit_s;
  logic [NCH-1:0] term_s;

  // Terminal-count and write-select decode; a half-period of 0 counts as 1.
  always_comb begin
    wr_hit_s = {NCH{1'b0}};
    term_s   = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (active_r[i] == ZERO_P) begin
        last_s[i] = ZERO_P;
      end else begin
        last_s[i] = active_r[i] - ONE_P;
      end
      wr_hit_s[i] = wr_en && (wr_ch == 3'(i));
      term_s[i]   = (cnt_r[i] == last_s[i]);
    end
  end

  // Per-channel divider state; sync outranks disable, which outranks counting.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        active_r[i]  <= DEF_P;
        pending_r[i] <= DEF_P;
        cnt_r[i]     <= ZERO_P;
      end
      clk_r  <= {NCH{1'b0}};
      tick_r <= {NCH{1'b0}};
      busy_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync) begin
          cnt_r[i]  <= ZERO_P;
          clk_r[i]  <= 1'b0;
          tick_r[i] <= 1'b0;
          busy_r[i] <= 1'b0;
          if (wr_hit_s[i]) begin
            active_r[i]  <= wr_period;
            pending_r[i] <= wr_period;
          end else if (busy_r[i]) begin
            active_r[i] <= pending_r[i];
          end
        end else if (!en[i]) begin
          cnt_r[i]  <= ZERO_P;
          clk_r[i]  <= 1'b0;
          tick_r[i] <= 1'b0;
          // An idle channel takes a new period immediately; pending is kept otherwise.
          if (wr_hit_s[i]) begin
            active_r[i] <= wr_period;
            busy_r[i]   <= 1'b0;
          end
        end else begin
          if (term_s[i]) begin
            cnt_r[i]  <= ZERO_P;
            clk_r[i]  <= ~clk_r[i];
            tick_r[i] <= ~clk_r[i];
            if (busy_r[i]) begin
              active_r[i] <= pending_r[i];
            end
          end else begin
            cnt_r[i]  <= cnt_r[i] + ONE_P;
            tick_r[i] <= 1'b0;
          end
          if (wr_hit_s[i]) begin
            pending_r[i] <= wr_period;
            busy_r[i]    <= 1'b1;
          end else if (term_s[i]) begin
            busy_r[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign clk_out = clk_r;
  assign tick    = tick_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: directed scenarios plus random
// stimulus against a timestamp-based reference model of each channel.
module tb_clk_divider_bank;

  localparam int NCH = 4;
  localparam int PW  = 30;
  localparam int DEF = 10;

  logic           CLK_50M = 1'b0;
  logic           RST = 1'b1;
  logic [NCH-1:0] en = 4'b0000;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_ch = 3'd0;
  logic [PW-1:0]  wr_period = 30'd0;
  logic           sync = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  int nvec = 0;
  int nerr = 0;
  int n = 0;

  // Reference model: each channel remembers the edge number at which its
  // current phase began; it toggles when 'eff' edges have elapsed since then.
  int             m_active  [NCH];
  int             m_pending [NCH];
  int             m_start   [NCH];
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_busy;

  clk_divider_bank #(.NCH(NCH), .PW(PW), .DEFAULT_PERIOD(DEF)) dut (
    .CLK_50M(CLK_50M), .RST(RST), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .sync(sync), .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 CLK_50M = ~CLK_50M;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_active[i]  = DEF;
      m_pending[i] = DEF;
      m_start[i]   = n;
    end
    m_clk  = '0;
    m_tick = '0;
    m_busy = '0;
  endtask

  task automatic model_edge();
    int eff;
    bit hit;
    n++;
    for (int i = 0; i < NCH; i++) begin
      hit = wr_en && (int'(wr_ch) == i);
      eff = (m_active[i] == 0) ? 1 : m_active[i];
      if (sync) begin
        m_start[i] = n;
        m_clk[i]   = 1'b0;
        m_tick[i]  = 1'b0;
        if (hit) m_active[i] = int'(wr_period);
        else if (m_busy[i]) m_active[i] = m_pending[i];
        m_busy[i] = 1'b0;
      end else if (!en[i]) begin
        m_start[i] = n;
        m_clk[i]   = 1'b0;
        m_tick[i]  = 1'b0;
        if (hit) begin
          m_active[i] = int'(wr_period);
          m_busy[i]   = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
        if (n - m_start[i] == eff) begin
          m_clk[i]   = ~m_clk[i];
          m_tick[i]  = m_clk[i];
          m_start[i] = n;
          if (m_busy[i]) begin
            m_active[i] = m_pending[i];
            m_busy[i]   = 1'b0;
          end
        end
        if (hit) begin
          m_pending[i] = int'(wr_period);
          m_busy[i]    = 1'b1;
        end
      end
    end
  endtask

  // Advance one clock: model first (pre-edge inputs), then the DUT edge.
  task automatic step();
    model_edge();
    @(posedge CLK_50M);
    #1;
    wr_en = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic do_write(input int ch, input int p);
    wr_en = 1'b1;
    wr_ch = 3'(ch);
    wr_period = 30'(p);
    step();
  endtask

  task automatic test_reset();
    #2;
    nvec++;
    if ({clk_out, tick, busy} !== 12'h000) begin
      nerr++;
      $display("FAIL reset: got clk=%b tick=%b busy=%b want all 0", clk_out, tick, busy);
    end
    model_reset();
    #1 RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL reset_idle: got %b/%b/%b want %b/%b/%b", clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
    end
  endtask

  task automatic test_enable();
    int ticks = 0;
    do_write(0, 3);
    nvec++;
    if (busy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL enable_busy: got busy0=%b want 0", busy[0]);
    end
    en = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k > 3 && tick[0] === 1'b1) ticks++;
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL enable_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
      if (k == 3) begin
        nvec++;
        if ({clk_out[0], tick[0]} !== 2'b11) begin
          nerr++;
          $display("FAIL enable_first_rise: got clk0=%b tick0=%b want 1 1", clk_out[0], tick[0]);
        end
      end
    end
    nvec++;
    if (ticks !== 2) begin
      nerr++;
      $display("FAIL enable_tick_rate: got %0d ticks want 2", ticks);
    end
  endtask

  task automatic test_busy_update();
    do_write(1, 4);
    en = 4'b0011;
    for (int k = 1; k <= 5; k++) step();
    nvec++;
    if (clk_out[1] !== 1'b1) begin
      nerr++;
      $display("FAIL busy_rise: got clk1=%b want 1", clk_out[1]);
    end
    do_write(1, 2);
    nvec++;
    if ({clk_out[1], busy[1]} !== 2'b11) begin
      nerr++;
      $display("FAIL busy_set: got clk1=%b busy1=%b want 1 1", clk_out[1], busy[1]);
    end
    step();
    nvec++;
    if ({clk_out[1], busy[1]} !== 2'b11) begin
      nerr++;
      $display("FAIL busy_hold_phase: got clk1=%b busy1=%b want 1 1", clk_out[1], busy[1]);
    end
    step();
    nvec++;
    if ({clk_out[1], busy[1]} !== 2'b00) begin
      nerr++;
      $display("FAIL busy_apply: got clk1=%b busy1=%b want 0 0", clk_out[1], busy[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL busy_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
    end
  endtask

  task automatic test_zero_period();
    int ticks = 0;
    do_write(2, 0);
    en = 4'b0111;
    step();
    nvec++;
    if (clk_out[2] !== 1'b1) begin
      nerr++;
      $display("FAIL zero_first: got clk2=%b want 1", clk_out[2]);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (tick[2] === 1'b1) ticks++;
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL zero_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
    end
    nvec++;
    if (ticks !== 4) begin
      nerr++;
      $display("FAIL zero_tick_rate: got %0d ticks want 4", ticks);
    end
  endtask

  task automatic test_sync();
    en = 4'b0011;
    do_write(1, 5);
    sync = 1'b1;
    step();
    nvec++;
    if ({clk_out[1:0], busy} !== 6'b00_0000) begin
      nerr++;
      $display("FAIL sync_clear: got clk=%b busy=%b want 00 0000", clk_out[1:0], busy);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL sync_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
      if (k == 15) begin
        nvec++;
        if (tick[1:0] !== 2'b11) begin
          nerr++;
          $display("FAIL sync_aligned: got tick=%b want 11", tick[1:0]);
        end
      end
    end
  endtask

  task automatic test_sync_write();
    wr_en = 1'b1;
    wr_ch = 3'd1;
    wr_period = 30'd7;
    sync = 1'b1;
    step();
    nvec++;
    if (busy[1] !== 1'b0) begin
      nerr++;
      $display("FAIL sync_write_busy: got busy1=%b want 0", busy[1]);
    end
    for (int k = 0; k < 7; k++) step();
    nvec++;
    if ({clk_out[1], tick[1]} !== 2'b11) begin
      nerr++;
      $display("FAIL sync_write_period: got clk1=%b tick1=%b want 1 1", clk_out[1], tick[1]);
    end
    do_write(5, 9);
    nvec++;
    if (busy !== 4'b0000) begin
      nerr++;
      $display("FAIL bad_channel_busy: got busy=%b want 0000", busy);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL bad_channel_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 4'b1000;
    step();
    do_write(3, 6);
    nvec++;
    if (busy[3] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_busy: got busy3=%b want 1", busy[3]);
    end
    RST = 1'b1;
    #2;
    nvec++;
    if ({clk_out, tick, busy} !== 12'h000) begin
      nerr++;
      $display("FAIL mid_reset_async: got clk=%b tick=%b busy=%b want all 0", clk_out, tick, busy);
    end
    model_reset();
    #1 RST = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL mid_model cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
      if (k == 10) begin
        nvec++;
        if ({clk_out[3], tick[3]} !== 2'b11) begin
          nerr++;
          $display("FAIL mid_default_period: got clk3=%b tick3=%b want 1 1", clk_out[3], tick[3]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) en = 4'($urandom);
      wr_en     = ($urandom_range(0, 5) == 0);
      wr_ch     = 3'($urandom_range(0, 5));
      wr_period = 30'($urandom_range(0, 6));
      sync      = ($urandom_range(0, 59) == 0);
      step();
      nvec++;
      if ({clk_out, tick, busy} !== {m_clk, m_tick, m_busy}) begin
        nerr++;
        $display("FAIL random cyc %0d: got %b/%b/%b want %b/%b/%b", k, clk_out, tick, busy, m_clk, m_tick, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_busy_update();
    test_zero_period();
    test_sync();
    test_sync_write();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
